// File: rtl/ci_initiator_if.sv
// rtl/ci_initiator_if.sv - request/response and CI bus signals of the CI initiator
interface ci_initiator_if;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqCiN;
  logic [31:0] reqValueA;
  logic [31:0] reqValueB;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspResult;
  logic        rspTimeout;
  logic        stall;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        spuriousDone;

  modport master (
    input  reqValid, reqCiN, reqValueA, reqValueB, rspReady, stall, ciDone, ciResult,
    output reqReady, rspValid, rspResult, rspTimeout, ciStart, ciN, ciValueA, ciValueB,
           spuriousDone
  );

  modport slave (
    output reqValid, reqCiN, reqValueA, reqValueB, rspReady, stall, ciDone, ciResult,
    input  reqReady, rspValid, rspResult, rspTimeout, ciStart, ciN, ciValueA, ciValueB,
           spuriousDone
  );
endinterface

// File: rtl/ci_initiator.sv
// rtl/ci_initiator.sv - single-outstanding custom-instruction initiator with timeout
module ci_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clock,
  input  logic           reset,
  ci_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  n_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [15:0] count;
  logic [31:0] result_q;
  logic        timeout_q;
  logic        spurious_q;
  logic        accept;
  logic        issue_go;
  logic        capture;
  logic        timed_out;
  logic        active;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue_go   = 1'b0;
    capture    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reqValid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.stall) begin
          issue_go   = 1'b1;
          capture    = bus.ciDone;
          state_next = bus.ciDone ? RESP : WAIT;
        end
      end
      WAIT: begin
        // A done arriving on the final count still beats the timeout
        if (bus.ciDone) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (count == LAST_COUNT) begin
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rspReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n_q        <= 8'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      count      <= 16'd0;
      result_q   <= 32'd0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        n_q <= bus.reqCiN;
        a_q <= bus.reqValueA;
        b_q <= bus.reqValueB;
      end
      // The start cycle itself counts as the first waited cycle
      if (issue_go) count <= 16'd1;
      else if (state == WAIT) count <= count + 16'd1;
      if (capture) begin
        result_q  <= bus.ciResult;
        timeout_q <= 1'b0;
      end else if (timed_out) begin
        result_q  <= 32'd0;
        timeout_q <= 1'b1;
      end
      if (bus.ciDone && (state == IDLE || state == RESP)) spurious_q <= 1'b1;
    end
  end

  assign active           = (state == ISSUE) || (state == WAIT);
  assign bus.reqReady     = (state == IDLE) && reset;
  assign bus.ciStart      = (state == ISSUE) && !bus.stall;
  assign bus.ciN          = active ? n_q : 8'd0;
  assign bus.ciValueA     = active ? a_q : 32'd0;
  assign bus.ciValueB     = active ? b_q : 32'd0;
  assign bus.rspValid     = (state == RESP);
  assign bus.rspResult    = result_q;
  assign bus.rspTimeout   = timeout_q;
  assign bus.spuriousDone = spurious_q;
endmodule
